// File: rtl/uart_mike_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Every output comes from a flop, loaded from the next-state decode.
module uart_mike_tx #(
  parameter int unsigned UART_DATA_WIDTH = 8,
  parameter int unsigned CLKS_PER_BIT    = 16,
  parameter int unsigned PARITY_EN       = 1,
  parameter int unsigned PARITY_ODD      = 0,
  parameter int unsigned STOP_BITS       = 1
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [UART_DATA_WIDTH-1:0] tx_data,
  input  logic                       tx_send,
  output logic                       tx,
  output logic                       tx_busy,
  output logic                       tx_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = $clog2(UART_DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(UART_DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           clk_cnt, clk_cnt_nxt;
  logic [BIT_W-1:0]           bit_cnt, bit_cnt_nxt;
  logic [UART_DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic                       parity_bit, parity_nxt;
  logic                       bit_end;
  logic                       tx_nxt, busy_nxt, done_nxt;

  // State, counters, datapath and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      clk_cnt    <= clk_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift_reg  <= shift_nxt;
      parity_bit <= parity_nxt;
      tx         <= tx_nxt;
      tx_busy    <= busy_nxt;
      tx_done    <= done_nxt;
    end
  end

  // Next-state decode; outputs are derived from the state about to be entered
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    parity_nxt  = parity_bit;
    bit_end     = (clk_cnt == CNT_LAST);
    tx_nxt      = 1'b1;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;

    if (state != IDLE) begin
      clk_cnt_nxt = bit_end ? '0 : clk_cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        if (tx_send) begin
          shift_nxt  = tx_data;
          parity_nxt = (^tx_data) ^ 1'(PARITY_ODD);
          state_nxt  = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = shift_reg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt   = STOP;
          bit_cnt_nxt = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = parity_nxt;
      default: tx_nxt = 1'b1;
    endcase

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == STOP) && (clk_cnt_nxt == CNT_LAST) &&
               (bit_cnt_nxt == STOP_LAST);
  end

endmodule

// File: tb/tb_uart_mike_tx.sv
// Bench for uart_mike_tx: three parameterisations checked against an expected
// bit sequence per frame and a behavioural mid-bit sampling receiver.
module tb_uart_mike_tx;

  localparam int CPB = 16;

  logic       clk;
  logic       n_rst;
  logic [2:0] send_v;
  logic [7:0] data_v [3];
  logic [2:0] tx_v, busy_v, done_v;

  int errors = 0;
  int checks = 0;

  // Instance configs: 0 = defaults, 1 = odd parity, 2 = no parity + 2 stop bits
  int par_en_c  [3] = '{1, 1, 0};
  int par_odd_c [3] = '{0, 1, 0};
  int stops_c   [3] = '{1, 1, 2};

  uart_mike_tx u_def (
    .clk(clk), .n_rst(n_rst), .tx_data(data_v[0]), .tx_send(send_v[0]),
    .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

  uart_mike_tx #(.PARITY_ODD(1)) u_odd (
    .clk(clk), .n_rst(n_rst), .tx_data(data_v[1]), .tx_send(send_v[1]),
    .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

  uart_mike_tx #(.PARITY_EN(0), .STOP_BITS(2)) u_np2 (
    .clk(clk), .n_rst(n_rst), .tx_data(data_v[2]), .tx_send(send_v[2]),
    .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request at the current negedge and check every cycle of the frame.
  // hold: keep tx_send high with hold_d through the frame; abort_c: reset at that cycle.
  task automatic frame(input int i, input logic [7:0] d, input bit hold,
                       input logic [7:0] hold_d, input int abort_c);
    logic exp_bits [$];
    int   len;
    exp_bits.push_back(1'b0);
    for (int b = 0; b < 8; b++) exp_bits.push_back(d[b]);
    if (par_en_c[i] != 0) exp_bits.push_back((^d) ^ 1'(par_odd_c[i]));
    for (int s = 0; s < stops_c[i]; s++) exp_bits.push_back(1'b1);
    len = exp_bits.size() * CPB;

    send_v[i] = 1'b1;
    data_v[i] = d;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) data_v[i] = hold_d;
        else begin
          send_v[i] = 1'b0;
          data_v[i] = 8'($urandom);
        end
      end
      chk($sformatf("tx i%0d d%h c%0d", i, d, c), tx_v[i], exp_bits[(c - 1) / CPB]);
      chk($sformatf("busy i%0d d%h c%0d", i, d, c), busy_v[i], 1'b1);
      chk($sformatf("done i%0d d%h c%0d", i, d, c), done_v[i], (c == len));
      if (c == abort_c) begin
        #2 n_rst = 1'b0;
        #1;
        chk("abort_tx", tx_v[i], 1'b1);
        chk("abort_busy", busy_v[i], 1'b0);
        chk("abort_done", done_v[i], 1'b0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk($sformatf("abort_hold_tx k%0d", k), tx_v[i], 1'b1);
          chk($sformatf("abort_hold_done k%0d", k), done_v[i], 1'b0);
        end
        n_rst = 1'b1;
        return;
      end
    end
    @(negedge clk);
    chk($sformatf("post_busy i%0d d%h", i, d), busy_v[i], 1'b0);
    chk($sformatf("post_tx i%0d d%h", i, d), tx_v[i], 1'b1);
    chk($sformatf("post_done i%0d d%h", i, d), done_v[i], 1'b0);
  endtask

  // Behavioural receiver: find the start bit, then sample each bit at mid-period.
  task automatic loopback(input int i, input logic [7:0] w);
    logic [7:0] rx;
    logic       pb, perr;
    int         t;
    send_v[i] = 1'b1;
    data_v[i] = w;
    @(negedge clk);
    send_v[i] = 1'b0;
    t = 0;
    while (tx_v[i] !== 1'b0 && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("lb_start_seen i%0d", i), tx_v[i], 1'b0);
    repeat (CPB / 2 - 1) @(negedge clk);
    chk($sformatf("lb_start_mid i%0d", i), tx_v[i], 1'b0);
    rx = '0;
    for (int b = 0; b < 8; b++) begin
      repeat (CPB) @(negedge clk);
      rx[b] = tx_v[i];
    end
    if (par_en_c[i] != 0) begin
      repeat (CPB) @(negedge clk);
      pb   = tx_v[i];
      perr = ((^rx) ^ pb) != 1'(par_odd_c[i]);
      chk($sformatf("lb_parity_error i%0d w%h", i, w), perr, 1'b0);
    end
    for (int s = 0; s < stops_c[i]; s++) begin
      repeat (CPB) @(negedge clk);
      chk($sformatf("lb_stop i%0d s%0d", i, s), tx_v[i], 1'b1);
    end
    chk8($sformatf("lb_byte i%0d", i), rx, w);
    t = 0;
    while (busy_v[i] !== 1'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("lb_idle i%0d", i), busy_v[i], 1'b0);
  endtask

  initial begin
    send_v = '0;
    for (int i = 0; i < 3; i++) data_v[i] = '0;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx i%0d", i), tx_v[i], 1'b1);
      chk($sformatf("rst_busy i%0d", i), busy_v[i], 1'b0);
      chk($sformatf("rst_done i%0d", i), done_v[i], 1'b0);
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Plan 1-3: basic frames per configuration
    frame(0, 8'hA5, 1'b0, 8'h00, 0);
    frame(1, 8'h00, 1'b0, 8'h00, 0);
    frame(2, 8'hFF, 1'b0, 8'h00, 0);

    // Plan 4: held request is ignored mid-frame, then starts gap-free
    frame(0, 8'h3C, 1'b1, 8'h81, 0);
    frame(0, 8'h81, 1'b0, 8'h00, 0);

    // Plan 5: reset during data bit 3 (cycles 65..80), then a clean frame
    frame(0, 8'h55, 1'b0, 8'h00, 70);
    frame(0, 8'h0F, 1'b0, 8'h00, 0);

    // Plan 6: random words through the behavioural receiver
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 4; n++) loopback(i, 8'($urandom_range(0, 255)));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
